// File: rtl/stack_unit_if.sv
// Operand stack command/status bundle.
// Datapath controller drives commands; stack returns data and status.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);

  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push,
    output pop,
    output tos,
    output din,
    output err_clr,
    input  dout,
    input  count,
    input  empty,
    input  full,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  push,
    input  pop,
    input  tos,
    input  din,
    input  err_clr,
    output dout,
    output count,
    output empty,
    output full,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/stack_unit.sv
// Hardware operand stack with registered read port.
// Push/pop/peek with full/empty status and sticky error flags.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  stack_unit_if.slave sif
);

  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_REPL,
    OP_BYP,
    OP_PUSH,
    OP_OVF,
    OP_POP,
    OP_UNF,
    OP_TOS
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;

  logic             empty_w;
  logic             full_w;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nxt_idx;
  logic [WIDTH-1:0] top_val;
  op_e              op;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // Slot of the current top entry and of the next free slot.
  // Only consulted when the count makes them valid.
  assign top_idx = AW'(count_q - CW'(1));
  assign nxt_idx = AW'(count_q);
  assign top_val = mem_q[top_idx];

  // Classify this cycle's command; push/pop outrank tos.
  always_comb begin
    op = OP_NONE;
    unique case (1'b1)
      sif.push && sif.pop:
        op = empty_w ? OP_BYP : OP_REPL;
      sif.push && !sif.pop:
        op = full_w ? OP_OVF : OP_PUSH;
      sif.pop && !sif.push:
        op = empty_w ? OP_UNF : OP_POP;
      sif.tos && !sif.push && !sif.pop:
        op = empty_w ? OP_UNF : OP_TOS;
      default:
        op = OP_NONE;
    endcase
  end

  // Next count, read data and flags; a new error beats err_clr.
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q & ~sif.err_clr;
    unf_d   = unf_q & ~sif.err_clr;
    unique case (op)
      OP_REPL: dout_d = top_val;
      OP_BYP:  dout_d = sif.din;
      OP_PUSH: count_d = count_q + CW'(1);
      OP_OVF:  ovf_d = 1'b1;
      OP_POP: begin
        dout_d  = top_val;
        count_d = count_q - CW'(1);
      end
      OP_UNF:  unf_d = 1'b1;
      OP_TOS:  dout_d = top_val;
      default: ;
    endcase
  end

  // Control state; cleared at once when rst drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents survive reset as don't-care.
  always_ff @(posedge clk) begin
    if (op == OP_PUSH) begin
      mem_q[nxt_idx] <= sif.din;
    end else if (op == OP_REPL) begin
      mem_q[top_idx] <= sif.din;
    end
  end

  assign sif.dout      = dout_q;
  assign sif.count     = count_q;
  assign sif.empty     = empty_w;
  assign sif.full      = full_w;
  assign sif.overflow  = ovf_q;
  assign sif.underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit.
// Queue model checked every cycle plus literal expectations.
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk;
  logic rst;

  stack_unit_if #(.WIDTH(WIDTH), .CW(CW)) sif ();

  stack_unit #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  logic [WIDTH-1:0] m_stk [$];
  logic [WIDTH-1:0] m_dout;
  bit               m_ovf;
  bit               m_unf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_dout = '0;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  task automatic model_op(input bit pu, input bit po,
                          input bit to,
                          input logic [WIDTH-1:0] d,
                          input bit clr);
    int n;
    n = m_stk.size();
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (pu && po) begin
      if (n > 0) begin
        m_dout = m_stk[n-1];
        m_stk[n-1] = d;
      end else begin
        m_dout = d;
      end
    end else if (pu) begin
      if (n < DEPTH) m_stk.push_back(d);
      else m_ovf = 1;
    end else if (po) begin
      if (n > 0) m_dout = m_stk.pop_back();
      else m_unf = 1;
    end else if (to) begin
      if (n > 0) m_dout = m_stk[n-1];
      else m_unf = 1;
    end
  endtask

  task automatic step(input bit pu, input bit po,
                      input bit to,
                      input logic [WIDTH-1:0] d,
                      input bit clr);
    @(negedge clk);
    sif.push    = pu;
    sif.pop     = po;
    sif.tos     = to;
    sif.din     = d;
    sif.err_clr = clr;
    @(posedge clk);
    model_op(pu, po, to, d, clr);
    #1;
    sif.push    = 0;
    sif.pop     = 0;
    sif.tos     = 0;
    sif.err_clr = 0;
  endtask

  // Model comparison, once per cycle away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_count", sif.count, m_stk.size());
      chk("m_empty", sif.empty, m_stk.size() == 0);
      chk("m_full", sif.full, m_stk.size() == DEPTH);
      chk("m_dout", sif.dout, m_dout);
      chk("m_ovf", sif.overflow, m_ovf);
      chk("m_unf", sif.underflow, m_unf);
    end
  end

  initial begin
    sif.push    = 0;
    sif.pop     = 0;
    sif.tos     = 0;
    sif.din     = '0;
    sif.err_clr = 0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cmp_en = 1;
    step(0, 0, 0, 8'h00, 0);
    chk("rst_count", sif.count, 0);
    chk("rst_empty", sif.empty, 1);
    chk("rst_full", sif.full, 0);
    chk("rst_dout", sif.dout, 8'h00);
    chk("rst_ovf", sif.overflow, 0);
    chk("rst_unf", sif.underflow, 0);

    step(1, 0, 0, 8'h11, 0);
    step(1, 0, 0, 8'h22, 0);
    step(1, 0, 0, 8'h33, 0);
    chk("lifo_cnt3", sif.count, 3);
    step(0, 1, 0, 8'h00, 0);
    chk("pop1_dout", sif.dout, 8'h33);
    chk("pop1_cnt", sif.count, 2);
    step(0, 1, 0, 8'h00, 0);
    chk("pop2_dout", sif.dout, 8'h22);
    chk("pop2_cnt", sif.count, 1);
    step(0, 1, 0, 8'h00, 0);
    chk("pop3_dout", sif.dout, 8'h11);
    chk("pop3_cnt", sif.count, 0);
    chk("pop3_empty", sif.empty, 1);

    for (int i = 1; i <= DEPTH; i++)
      step(1, 0, 0, 8'(i), 0);
    chk("fill_full", sif.full, 1);
    chk("fill_cnt", sif.count, 8);
    step(1, 0, 0, 8'h99, 0);
    chk("ovf_flag", sif.overflow, 1);
    chk("ovf_cnt", sif.count, 8);
    step(0, 1, 0, 8'h00, 0);
    chk("ovf_pop", sif.dout, 8'h08);
    for (int i = 0; i < DEPTH - 1; i++)
      step(0, 1, 0, 8'h00, 0);
    chk("drain_dout", sif.dout, 8'h01);
    chk("drain_empty", sif.empty, 1);

    step(0, 1, 0, 8'h00, 0);
    chk("unf_pop", sif.underflow, 1);
    chk("unf_pop_dout", sif.dout, 8'h01);
    step(0, 0, 1, 8'h00, 0);
    chk("unf_tos_dout", sif.dout, 8'h01);
    step(0, 0, 0, 8'h00, 1);
    chk("clr_unf", sif.underflow, 0);
    chk("clr_ovf", sif.overflow, 0);
    step(0, 1, 0, 8'h00, 1);
    chk("clr_set_wins", sif.underflow, 1);
    step(0, 0, 0, 8'h00, 1);

    step(1, 0, 0, 8'h05, 0);
    step(0, 0, 1, 8'h00, 0);
    chk("tos1_dout", sif.dout, 8'h05);
    step(0, 0, 1, 8'h00, 0);
    chk("tos2_dout", sif.dout, 8'h05);
    chk("tos2_cnt", sif.count, 1);
    step(1, 1, 1, 8'h0A, 0);
    chk("repl_dout", sif.dout, 8'h05);
    chk("repl_cnt", sif.count, 1);
    step(0, 1, 0, 8'h00, 0);
    chk("repl_pop", sif.dout, 8'h0A);
    chk("unf_none", sif.underflow, 0);

    step(1, 0, 0, 8'h44, 0);
    step(1, 0, 0, 8'h55, 0);
    step(0, 0, 1, 8'h00, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_cnt", sif.count, 0);
    chk("arst_dout", sif.dout, 8'h00);
    chk("arst_empty", sif.empty, 1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1, 1, 0, 8'h77, 0);
    chk("byp_dout", sif.dout, 8'h77);
    chk("byp_cnt", sif.count, 0);
    chk("byp_unf", sif.underflow, 0);
    step(0, 1, 0, 8'h00, 0);
    chk("post_rst_unf", sif.underflow, 1);

    @(negedge clk);
    #1;
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack consumed by the stack-machine datapath; services the controller's push, pop and top-of-stack (ToS) commands.
- Stores ALU results and memory operands pushed by the datapath.
- Returns popped or peeked values on a registered output, which the datapath latches into its A/B operand registers.
- Provides full/empty status and sticky overflow/underflow error flags for the controller and debug.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 8: number of stack entries; any integer >= 2.
- CW, 4: width of `count`; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous reset, active-low; all state clears immediately while low.
- push  in  1  write `din` onto the stack this cycle.
- pop  in  1  remove the top entry and present it on `dout`.
- tos  in  1  present the top entry on `dout` without removing it.
- din  in  WIDTH  data to push.
- err_clr  in  1  synchronous clear of the sticky error flags.
- dout  out  WIDTH  registered read data.
- count  out  CW  number of valid entries, 0..DEPTH.
- empty  out  1  high when count==0 (combinational from count).
- full  out  1  high when count==DEPTH (combinational from count).
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop or tos was attempted while empty.

Behaviour:
- Reset (rst low, asynchronous): count=0, dout=0, overflow=0, underflow=0; therefore empty=1, full=0. Storage array contents are not reset and are don't-care.
- All operations below take effect on the rising edge of clk. `dout` is updated on the same edge, so data is valid one cycle after the command, which matches the controller's multi-cycle load of A/B.
- Command decode, evaluated in priority order each cycle:
  1. push=1, pop=1, count>0 (replace-top): dout<=mem[count-1]; mem[count-1]<=din; count unchanged.
  2. push=1, pop=1, count==0 (bypass): dout<=din; count stays 0; no error.
  3. push=1, pop=0, not full: mem[count]<=din; count<=count+1; dout unchanged.
  4. push=1, pop=0, full: no write; count and dout unchanged; overflow<=1.
  5. pop=1, push=0, not empty: dout<=mem[count-1]; count<=count-1.
  6. pop=1, push=0, empty: count and dout unchanged; underflow<=1.
  7. tos=1, push=0, pop=0, not empty: dout<=mem[count-1]; count unchanged.
  8. tos=1, push=0, pop=0, empty: dout unchanged; underflow<=1.
  9. No command: all state holds.
- `tos` is ignored whenever push or pop is asserted.
- Push-then-pop on consecutive cycles returns the just-pushed value. Storage is a register array, so the written entry is readable on the next cycle.
- err_clr=1 clears overflow and underflow at the clock edge. If an error event occurs in the same cycle, the set wins and the flag ends at 1.
- count never exceeds DEPTH and never wraps below 0; a rejected operation leaves count unchanged.
- A reset asserted mid-sequence discards all entries. After rst deasserts, the first pop raises underflow.

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, dout=0x00, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33 on three cycles; then pop, pop, pop -> dout=0x33, 0x22, 0x11 on the cycle after each pop; count 3->2->1->0; empty=1 at the end.
- Push DEPTH(8) values 0x01..0x08 -> full=1. Push 0x99 -> overflow=1, count stays 8. Pop -> dout=0x08, not 0x99.
- On empty: pop, then tos -> underflow=1, dout unchanged. err_clr=1 for one cycle -> underflow=0. err_clr together with an empty pop -> underflow stays 1.
- Push 0x05, then tos twice -> dout=0x05 both times, count stays 1. Then push=1, pop=1 with din=0x0A -> dout=0x05, count=1, and the next pop gives dout=0x0A.
- Push 0x44 and 0x55, then pull rst low between clock edges -> count=0 and dout=0 immediately, without waiting for an edge. Release rst, then push=1, pop=1 with din=0x77 -> dout=0x77 (bypass), count=0.
